// File: rtl/cva6_hpdcache_req_arbiter.sv
// Shares the HPDcache core request port among NREQ requesters. The arbiter is round-robin
// and holds a grant until the cache accepts it. Responses are routed back by sid, with per-requester throttling.
module cva6_hpdcache_req_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned REQ_W     = 128,
  parameter int unsigned RSP_W     = 96,
  parameter int unsigned SID_W     = 3,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ-1:0]       req_need_rsp_i,
  input  logic [NREQ*REQ_W-1:0] req_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  dcache_req_valid_o,
  input  logic                  dcache_req_ready_i,
  output logic [REQ_W-1:0]      dcache_req_o,
  output logic [SID_W-1:0]      dcache_req_sid_o,
  input  logic                  dcache_rsp_valid_i,
  input  logic [SID_W-1:0]      dcache_rsp_sid_i,
  input  logic [RSP_W-1:0]      dcache_rsp_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  output logic [RSP_W-1:0]      rsp_o,
  output logic                  rsp_sid_err_o,
  output logic                  dbg_state_o
);
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  // Handshake: a request transfers on a cycle where dcache_req_valid_o && dcache_req_ready_i; once
  // valid is raised for a requester the grant stays on it until that transfer happens.
  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_q, lock_idx_q;
  logic [CNT_W-1:0] outst_q [NREQ];

  logic [NREQ-1:0]  elig, inc_v, dec_v;
  logic             arb_found, sel_valid, sel_need, req_accept, sid_known, zero_hit;
  logic [IDX_W-1:0] arb_idx, grant_idx, next_rr;
  logic [REQ_W-1:0] sel_req;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid_i[i] && ((outst_q[i] < CNT_W'(MAX_OUTST)) || !req_need_rsp_i[i]);
    end
  end

  // First eligible requester at or after rr_q, wrapping modulo NREQ.
  always_comb begin : p_arb
    int idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!arb_found && (i == idx) && elig[i]) begin
          arb_found = 1'b1;
          arb_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign grant_idx = (state_q == LOCKED) ? lock_idx_q : arb_idx;
  assign next_rr   = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_comb begin
    sel_req   = '0;
    sel_need  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_req   = req_i[i*REQ_W +: REQ_W];
        sel_need  = req_need_rsp_i[i];
        sel_valid = req_valid_i[i];
      end
    end
  end

  assign dcache_req_valid_o = (state_q == LOCKED) ? sel_valid : arb_found;
  assign dcache_req_o       = dcache_req_valid_o ? sel_req : '0;
  assign dcache_req_sid_o   = dcache_req_valid_o ? SID_W'(grant_idx) : '0;
  assign req_accept         = dcache_req_valid_o && dcache_req_ready_i;
  assign dbg_state_o        = (state_q == LOCKED);

  always_comb begin
    req_ready_o = '0;
    inc_v       = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = req_accept && (grant_idx == IDX_W'(i));
      inc_v[i]       = req_ready_o[i] && sel_need;
    end
  end

  // Responses are never back-pressured; an unknown sid or a response nobody is waiting for is flagged.
  always_comb begin
    rsp_valid_o = '0;
    dec_v       = '0;
    sid_known   = 1'b0;
    zero_hit    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (dcache_rsp_sid_i == SID_W'(i)) begin
        sid_known      = 1'b1;
        rsp_valid_o[i] = dcache_rsp_valid_i;
        zero_hit       = (outst_q[i] == '0);
        dec_v[i]       = dcache_rsp_valid_i && (outst_q[i] != '0);
      end
    end
    rsp_sid_err_o = dcache_rsp_valid_i && (!sid_known || zero_hit);
  end

  assign rsp_o = dcache_rsp_i;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst_i) begin
        outst_q[i] <= '0;
      end else if (inc_v[i] && !dec_v[i]) begin
        outst_q[i] <= outst_q[i] + CNT_W'(1);
      end else if (dec_v[i] && !inc_v[i]) begin
        outst_q[i] <= outst_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      rr_q       <= '0;
      lock_idx_q <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (req_accept) begin
            rr_q <= next_rr;
          end else if (dcache_req_valid_o) begin
            lock_idx_q <= arb_idx;
            state_q    <= LOCKED;
          end
        end
        LOCKED: begin
          // A requester dropping valid while locked releases the lock without moving priority.
          if (!dcache_req_valid_o) begin
            state_q <= ARB;
          end else if (dcache_req_ready_i) begin
            rr_q    <= next_rr;
            state_q <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_ready_o));
  a_rsp_onehot0   : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rsp_valid_o));
  a_locked_stable : assert property (@(posedge clk_i) disable iff (rst_i)
                      (state_q == LOCKED && dcache_req_valid_o) |-> (dcache_req_o == $past(dcache_req_o)));

endmodule

// File: tb/tb_cva6_hpdcache_req_arbiter.sv
// Self-checking bench for cva6_hpdcache_req_arbiter: accepted requests and routed responses are
// checked against expected queues; scenario tasks add inline checks on ready, lock and error state.
module tb_cva6_hpdcache_req_arbiter;
  localparam int NREQ      = 3;
  localparam int REQ_W     = 128;
  localparam int RSP_W     = 96;
  localparam int SID_W     = 3;
  localparam int MAX_OUTST = 4;
  localparam int AW        = SID_W + REQ_W;
  localparam int RW        = NREQ + 1 + RSP_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_need = '0;
  logic [NREQ*REQ_W-1:0] req_flat = '0;
  logic [NREQ-1:0]       req_ready_o;
  logic                  dcache_req_valid_o;
  logic                  dready = 1'b0;
  logic [REQ_W-1:0]      dcache_req_o;
  logic [SID_W-1:0]      dcache_req_sid_o;
  logic                  rsp_valid = 1'b0;
  logic [SID_W-1:0]      rsp_sid = '0;
  logic [RSP_W-1:0]      rsp_word = '0;
  logic [NREQ-1:0]       rsp_valid_o;
  logic [RSP_W-1:0]      rsp_o;
  logic                  rsp_sid_err_o;
  logic                  dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_q[$];
  logic [RW-1:0] exp_rsp_q[$];

  cva6_hpdcache_req_arbiter #(
    .NREQ(NREQ), .REQ_W(REQ_W), .RSP_W(RSP_W), .SID_W(SID_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (req_valid),
    .req_need_rsp_i    (req_need),
    .req_i             (req_flat),
    .req_ready_o       (req_ready_o),
    .dcache_req_valid_o(dcache_req_valid_o),
    .dcache_req_ready_i(dready),
    .dcache_req_o      (dcache_req_o),
    .dcache_req_sid_o  (dcache_req_sid_o),
    .dcache_rsp_valid_i(rsp_valid),
    .dcache_rsp_sid_i  (rsp_sid),
    .dcache_rsp_i      (rsp_word),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_o             (rsp_o),
    .rsp_sid_err_o     (rsp_sid_err_o),
    .dbg_state_o       (dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: pop expectations whenever the DUT transfers a request or routes a response.
  always @(negedge clk) begin : p_scoreboard
    logic [AW-1:0] ea;
    logic [RW-1:0] er;
    if (!rst && dcache_req_valid_o && dready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL acc_unexpected: got sid=%0d req=%h, required no transfer", dcache_req_sid_o, dcache_req_o);
      end else begin
        ea = exp_q.pop_front();
        if ({dcache_req_sid_o, dcache_req_o} !== ea) begin
          n_fail++;
          $display("FAIL acc_data: got sid=%0d req=%h, required sid=%0d req=%h",
                   dcache_req_sid_o, dcache_req_o, ea[AW-1:REQ_W], ea[REQ_W-1:0]);
        end
      end
    end
    if (!rst && rsp_valid) begin
      n_checks++;
      if (exp_rsp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b err=%b, required no response", rsp_valid_o, rsp_sid_err_o);
      end else begin
        er = exp_rsp_q.pop_front();
        if ({rsp_valid_o, rsp_sid_err_o, rsp_o} !== er) begin
          n_fail++;
          $display("FAIL rsp_route: got valid=%b err=%b rsp=%h, required valid=%b err=%b rsp=%h",
                   rsp_valid_o, rsp_sid_err_o, rsp_o, er[RW-1:RSP_W+1], er[RSP_W], er[RSP_W-1:0]);
        end
      end
    end
  end

  // Driver tasks
  function automatic logic [REQ_W-1:0] mk_req(input int i, input int n);
    return REQ_W'(64'h5EED_0000_0000 + 64'(n) * 256 + 64'(i));
  endfunction

  function automatic logic [RSP_W-1:0] mk_rsp(input int n);
    return RSP_W'(64'hFACE_0000_0000 + 64'(n) * 3 + 64'($urandom_range(0, 2)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic v, input logic need, input logic [REQ_W-1:0] w);
    req_valid[i] = v;
    req_need[i]  = need;
    req_flat[i*REQ_W +: REQ_W] = w;
  endtask

  task automatic drive_rsp(input logic v, input int sid, input logic [NREQ-1:0] exp_vld, input logic exp_err);
    rsp_valid = v;
    rsp_sid   = SID_W'(sid);
    rsp_word  = mk_rsp(sid + 40);
    if (v) exp_rsp_q.push_back({exp_vld, exp_err, rsp_word});
  endtask

  task automatic idle();
    req_valid = '0;
    req_need  = '0;
    req_flat  = '0;
    dready    = 1'b0;
    rsp_valid = 1'b0;
    rsp_sid   = '0;
    rsp_word  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if ({dcache_req_valid_o, req_ready_o, dcache_req_sid_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_req: got valid=%b ready=%b sid=%0d, required all 0", dcache_req_valid_o, req_ready_o, dcache_req_sid_o);
    end
    n_checks++;
    if ({rsp_valid_o, rsp_sid_err_o, dbg_state_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got rsp_valid=%b err=%b state=%b, required all 0", rsp_valid_o, rsp_sid_err_o, dbg_state_o);
    end
    n_checks++;
    if (dcache_req_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got req=%h, required 0", dcache_req_o);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    dready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      int g;
      for (int i = 0; i < NREQ; i++) drive_req(i, 1'b1, 1'b0, mk_req(i, n));
      g = n % NREQ;
      exp_q.push_back({SID_W'(g), mk_req(g, n)});
      @(negedge clk);
      n_checks++;
      if (req_ready_o !== NREQ'(1 << g)) begin
        n_fail++;
        $display("FAIL rr_ready: cycle %0d got %b, required %b", n, req_ready_o, NREQ'(1 << g));
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_lock();
    logic [REQ_W-1:0] w1;
    do_reset();
    w1 = mk_req(1, 100);
    drive_req(1, 1'b1, 1'b0, w1);
    for (int k = 0; k < 3; k++) begin
      if (k >= 1) drive_req(0, 1'b1, 1'b0, mk_req(0, 100 + k));
      @(negedge clk);
      n_checks++;
      if ({dcache_req_valid_o, dcache_req_sid_o, dcache_req_o, req_ready_o} !== {1'b1, SID_W'(1), w1, NREQ'(0)}) begin
        n_fail++;
        $display("FAIL lock_hold: cycle %0d got valid=%b sid=%0d req=%h ready=%b, required 1/1/%h/000",
                 k, dcache_req_valid_o, dcache_req_sid_o, dcache_req_o, req_ready_o, w1);
      end
      n_checks++;
      if (dbg_state_o !== (k > 0)) begin
        n_fail++;
        $display("FAIL lock_state: cycle %0d got %b, required %b", k, dbg_state_o, (k > 0));
      end
      tick();
    end
    dready = 1'b1;
    drive_req(2, 1'b1, 1'b0, mk_req(2, 103));
    exp_q.push_back({SID_W'(1), w1});
    @(negedge clk);
    n_checks++;
    if (req_ready_o !== 3'b010) begin
      n_fail++;
      $display("FAIL lock_release: got ready=%b, required 010", req_ready_o);
    end
    tick();
    drive_req(1, 1'b0, 1'b0, '0);
    exp_q.push_back({SID_W'(2), mk_req(2, 103)});
    tick();
    drive_req(2, 1'b0, 1'b0, '0);
    drive_req(0, 1'b1, 1'b0, mk_req(0, 105));
    exp_q.push_back({SID_W'(0), mk_req(0, 105)});
    tick();
    idle();
    tick();
  endtask

  task automatic test_lock_drop();
    do_reset();
    drive_req(1, 1'b1, 1'b0, mk_req(1, 150));
    tick();
    drive_req(1, 1'b0, 1'b0, '0);
    drive_req(0, 1'b1, 1'b0, mk_req(0, 151));
    dready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({dbg_state_o, dcache_req_valid_o, req_ready_o} !== {1'b1, 1'b0, NREQ'(0)}) begin
      n_fail++;
      $display("FAIL drop_idle: got state=%b valid=%b ready=%b, required 1/0/000", dbg_state_o, dcache_req_valid_o, req_ready_o);
    end
    tick();
    drive_req(2, 1'b1, 1'b0, mk_req(2, 152));
    exp_q.push_back({SID_W'(0), mk_req(0, 151)});
    @(negedge clk);
    n_checks++;
    if (dbg_state_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_state: got %b, required 0", dbg_state_o);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_outst_limit();
    do_reset();
    dready = 1'b1;
    for (int n = 0; n < MAX_OUTST; n++) begin
      drive_req(2, 1'b1, 1'b1, mk_req(2, 200 + n));
      exp_q.push_back({SID_W'(2), mk_req(2, 200 + n)});
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      int g;
      g = (k == 1) ? 1 : 0;
      drive_req(0, 1'b1, 1'b0, mk_req(0, 210 + k));
      drive_req(1, 1'b1, 1'b0, mk_req(1, 210 + k));
      drive_req(2, 1'b1, 1'b1, mk_req(2, 210 + k));
      exp_q.push_back({SID_W'(g), mk_req(g, 210 + k)});
      if (k == 2) drive_rsp(1'b1, 2, 3'b100, 1'b0);
      @(negedge clk);
      n_checks++;
      if (req_ready_o !== NREQ'(1 << g)) begin
        n_fail++;
        $display("FAIL cap_block: cycle %0d got ready=%b, required %b", k, req_ready_o, NREQ'(1 << g));
      end
      tick();
    end
    drive_rsp(1'b0, 0, '0, 1'b0);
    drive_req(0, 1'b0, 1'b0, '0);
    drive_req(1, 1'b0, 1'b0, '0);
    drive_req(2, 1'b1, 1'b1, mk_req(2, 220));
    exp_q.push_back({SID_W'(2), mk_req(2, 220)});
    @(negedge clk);
    n_checks++;
    if (req_ready_o !== 3'b100) begin
      n_fail++;
      $display("FAIL cap_unblock: got ready=%b, required 100", req_ready_o);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_simul_inc_dec();
    do_reset();
    dready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive_req(0, 1'b1, 1'b1, mk_req(0, 300 + n));
      exp_q.push_back({SID_W'(0), mk_req(0, 300 + n)});
      if (n == 2) drive_rsp(1'b1, 0, 3'b001, 1'b0);
      tick();
    end
    idle();
    // Counter must still hold 2: two clean responses, then the third is unexpected.
    for (int n = 0; n < 3; n++) begin
      drive_rsp(1'b1, 0, 3'b001, (n == 2));
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_sid_err();
    do_reset();
    drive_rsp(1'b1, 5, 3'b000, 1'b1);
    tick();
    drive_rsp(1'b0, 0, '0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid_o, rsp_sid_err_o} !== '0) begin
      n_fail++;
      $display("FAIL err_pulse: got rsp_valid=%b err=%b, required 000/0", rsp_valid_o, rsp_sid_err_o);
    end
    tick();
    drive_rsp(1'b1, 3, 3'b000, 1'b1);
    tick();
    drive_rsp(1'b1, 1, 3'b010, 1'b1);
    tick();
    drive_rsp(1'b0, 0, '0, 1'b0);
    dready = 1'b1;
    drive_req(1, 1'b1, 1'b1, mk_req(1, 400));
    exp_q.push_back({SID_W'(1), mk_req(1, 400)});
    tick();
    idle();
    drive_rsp(1'b1, 1, 3'b010, 1'b0);
    tick();
    drive_rsp(1'b1, 1, 3'b010, 1'b1);
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_locked();
    do_reset();
    dready = 1'b1;
    drive_req(0, 1'b1, 1'b1, mk_req(0, 500));
    exp_q.push_back({SID_W'(0), mk_req(0, 500)});
    tick();
    drive_req(0, 1'b1, 1'b1, mk_req(0, 501));
    exp_q.push_back({SID_W'(0), mk_req(0, 501)});
    tick();
    drive_req(0, 1'b0, 1'b0, '0);
    drive_req(1, 1'b1, 1'b1, mk_req(1, 502));
    exp_q.push_back({SID_W'(1), mk_req(1, 502)});
    tick();
    drive_req(1, 1'b0, 1'b0, '0);
    drive_req(2, 1'b1, 1'b0, mk_req(2, 503));
    dready = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dbg_state_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_locked: got state=%b, required 1", dbg_state_o);
    end
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    n_checks++;
    if ({dbg_state_o, dcache_req_valid_o, req_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_post_state: got state=%b valid=%b ready=%b, required 0/0/000", dbg_state_o, dcache_req_valid_o, req_ready_o);
    end
    tick();
    for (int s = 0; s < NREQ; s++) begin
      drive_rsp(1'b1, s, NREQ'(1 << s), 1'b1);
      tick();
    end
    drive_rsp(1'b0, 0, '0, 1'b0);
    dready = 1'b1;
    for (int i = 0; i < NREQ; i++) drive_req(i, 1'b1, 1'b0, mk_req(i, 510));
    exp_q.push_back({SID_W'(0), mk_req(0, 510)});
    tick();
    idle();
    tick();
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_lock_drop();
    test_outst_limit();
    test_simul_inc_dec();
    test_sid_err();
    test_reset_locked();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL acc_leftover: got %0d pending, required 0", exp_q.size());
    end
    n_checks++;
    if (exp_rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_leftover: got %0d pending, required 0", exp_rsp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
